// File: rtl/button_event_ctrl.sv
// Push-button front end: 2-FF sync, shared-tick debounce, per-button press/hold/repeat
// FSM and a round-robin arbitrated single event channel with a sticky overflow flag.
//
// state | meaning
// IDLE  | button released, waiting for a debounced press
// HELD  | pressed, counting down to the first REPEAT
// RPT   | auto-repeating, counting down between REPEATs
module button_event_ctrl #(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 4,
  parameter int STABLE_TICKS = 4,
  parameter int HOLD_TICKS   = 16,
  parameter int REPEAT_TICKS = 8,
  localparam int IDW = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             enable,
  input  logic [N_BTN-1:0] in,
  output logic [N_BTN-1:0] level,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDW-1:0]   evt_id,
  output logic [1:0]       evt_type,
  output logic             evt_ovf
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW   = $clog2(STABLE_TICKS);
  localparam int HMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;

  localparam logic [1:0] T_PRESS   = 2'd0;
  localparam logic [1:0] T_RELEASE = 2'd1;
  localparam logic [1:0] T_REPEAT  = 2'd2;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HELD = 2'd1, S_RPT = 2'd2} state_t;

  logic [N_BTN-1:0] sync1, sync2;
  logic [PW-1:0]    pre_cnt;
  logic             tick;
  logic [SW-1:0]    stab_cnt [N_BTN];
  logic [N_BTN-1:0] toggle, rise, fall;

  state_t           st    [N_BTN];
  state_t           st_nx [N_BTN];
  logic [HW-1:0]    rem    [N_BTN];
  logic [HW-1:0]    rem_nx [N_BTN];
  logic [N_BTN-1:0] post_v;
  logic [1:0]       post_t [N_BTN];

  logic [N_BTN-1:0] pend, occ, lost, gnt;
  logic [1:0]       ptype [N_BTN];
  logic [IDW-1:0]   rr_ptr, win;
  logic [IDW:0]     sel_j;
  logic             found, load;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
    end
  end

  assign tick = enable && (pre_cnt == PW'(TICK_DIV - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         pre_cnt <= '0;
    else if (enable) pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
  end

  always_comb begin
    toggle = '0;
    for (int i = 0; i < N_BTN; i++)
      toggle[i] = tick && (sync2[i] != level[i]) && (stab_cnt[i] == SW'(STABLE_TICKS - 1));
  end

  assign rise = toggle & ~level;
  assign fall = toggle & level;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      level <= '0;
      for (int i = 0; i < N_BTN; i++) stab_cnt[i] <= '0;
    end else begin
      level <= level ^ toggle;
      for (int i = 0; i < N_BTN; i++) begin
        if (tick) begin
          if (sync2[i] != level[i]) stab_cnt[i] <= toggle[i] ? '0 : stab_cnt[i] + SW'(1);
          else                      stab_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N_BTN; i++) begin
        st[i]  <= S_IDLE;
        rem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        st[i]  <= st_nx[i];
        rem[i] <= rem_nx[i];
      end
    end
  end

  // rem is a down-counter: ticks remaining until the next REPEAT
  always_comb begin
    post_v = '0;
    for (int i = 0; i < N_BTN; i++) begin
      st_nx[i]  = st[i];
      rem_nx[i] = rem[i];
      post_t[i] = T_PRESS;
      case (st[i])
        S_IDLE: begin
          if (rise[i]) begin
            st_nx[i]  = S_HELD;
            rem_nx[i] = HW'(HOLD_TICKS - 1);
            post_v[i] = 1'b1;
          end
        end
        S_HELD, S_RPT: begin
          if (fall[i]) begin
            st_nx[i]  = S_IDLE;
            post_v[i] = 1'b1;
            post_t[i] = T_RELEASE;
          end else if (tick) begin
            if (rem[i] == '0) begin
              st_nx[i]  = S_RPT;
              rem_nx[i] = HW'(REPEAT_TICKS - 1);
              post_v[i] = 1'b1;
              post_t[i] = T_REPEAT;
            end else begin
              rem_nx[i] = rem[i] - HW'(1);
            end
          end
        end
        default: st_nx[i] = S_IDLE;
      endcase
    end
  end

  // A slot being granted this cycle counts as free, so a same-cycle post is kept
  assign occ = pend & ~gnt;

  always_comb begin
    lost = '0;
    for (int i = 0; i < N_BTN; i++)
      lost[i] = post_v[i] && occ[i] && (post_t[i] != T_REPEAT);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend    <= '0;
      evt_ovf <= 1'b0;
      for (int i = 0; i < N_BTN; i++) ptype[i] <= T_PRESS;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (post_v[i] && !(occ[i] && post_t[i] == T_REPEAT)) begin
          pend[i]  <= 1'b1;
          ptype[i] <= post_t[i];
        end else if (gnt[i]) begin
          pend[i] <= 1'b0;
        end
      end
      if (|lost) evt_ovf <= 1'b1;
    end
  end

  assign load = ~evt_valid | evt_ready;

  always_comb begin
    found = 1'b0;
    win   = '0;
    sel_j = '0;
    for (int k = 0; k < N_BTN; k++) begin
      sel_j = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (sel_j >= (IDW+1)'(N_BTN)) sel_j = sel_j - (IDW+1)'(N_BTN);
      if (!found && pend[sel_j[IDW-1:0]]) begin
        found = 1'b1;
        win   = sel_j[IDW-1:0];
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (load && found) gnt[win] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_type  <= T_PRESS;
      rr_ptr    <= '0;
    end else if (load) begin
      if (found) begin
        evt_valid <= 1'b1;
        evt_id    <= win;
        evt_type  <= ptype[win];
        rr_ptr    <= (win == IDW'(N_BTN - 1)) ? '0 : win + IDW'(1);
      end else begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl: a vector table for the channel/slot behaviour
// plus hand-written sequences for glitches, hold/repeat timing, enable freeze and reset.
module tb_button_event_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       enable = 1'b1;
  logic [3:0] in = 4'b0000;
  logic       evt_ready = 1'b0;
  logic [3:0] level;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic [1:0] evt_type;
  logic       evt_ovf;

  button_event_ctrl dut (
    .CLK(CLK), .RST(RST), .enable(enable), .in(in), .level(level),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .evt_type(evt_type), .evt_ovf(evt_ovf)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { int cyc; int id; int typ; } xfer_t;
  xfer_t q[$];
  xfer_t mon_x;

  always @(negedge CLK) begin
    if (!RST && evt_valid && evt_ready) begin
      mon_x.cyc = cyc;
      mon_x.id  = int'(evt_id);
      mon_x.typ = int'(evt_type);
      q.push_back(mon_x);
    end
  end

  typedef struct { int in; int rdy; int n; int lvl; int vld; int id; int typ; int ovf; } vec_t;
  vec_t tbl [17];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input logic en);
    RST = 1'b1;
    in = 4'b0000;
    evt_ready = 1'b0;
    enable = en;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  initial begin
    int bad;
    int c0;
    //          in      rdy n   lvl     vld id typ ovf
    tbl[0]  = '{'b0000, 0, 2,  'b0000, 0, 0, 0, 0};
    tbl[1]  = '{'b0001, 0, 20, 'b0001, 1, 0, 0, 0};
    tbl[2]  = '{'b0000, 0, 20, 'b0000, 1, 0, 0, 0};
    tbl[3]  = '{'b0000, 1, 1,  'b0000, 1, 0, 1, 0};
    tbl[4]  = '{'b0000, 1, 1,  'b0000, 0, 0, 0, 0};
    tbl[5]  = '{'b0010, 0, 20, 'b0010, 1, 1, 0, 0};
    tbl[6]  = '{'b0110, 0, 20, 'b0110, 1, 1, 0, 0};
    tbl[7]  = '{'b0100, 0, 20, 'b0100, 1, 1, 0, 0};
    tbl[8]  = '{'b0100, 1, 1,  'b0100, 1, 2, 0, 0};
    tbl[9]  = '{'b0100, 1, 1,  'b0100, 1, 1, 1, 0};
    tbl[10] = '{'b0100, 1, 1,  'b0100, 0, 0, 0, 0};
    tbl[11] = '{'b0000, 1, 20, 'b0000, 0, 0, 0, 0};
    tbl[12] = '{'b0001, 0, 20, 'b0001, 1, 0, 0, 0};
    tbl[13] = '{'b0011, 0, 20, 'b0011, 1, 0, 0, 0};
    tbl[14] = '{'b0001, 0, 20, 'b0001, 1, 0, 0, 1};
    tbl[15] = '{'b0000, 1, 1,  'b0001, 1, 1, 1, 1};
    tbl[16] = '{'b0000, 1, 20, 'b0000, 0, 0, 0, 1};

    do_reset(1'b1);
    for (int i = 0; i < 17; i++) begin
      in = 4'(tbl[i].in);
      evt_ready = tbl[i].rdy[0];
      run(tbl[i].n);
      check($sformatf("v%0d level", i), int'(level), tbl[i].lvl);
      check($sformatf("v%0d valid", i), int'(evt_valid), tbl[i].vld);
      if (tbl[i].vld != 0) begin
        check($sformatf("v%0d id", i), int'(evt_id), tbl[i].id);
        check($sformatf("v%0d type", i), int'(evt_type), tbl[i].typ);
      end
      check($sformatf("v%0d ovf", i), int'(evt_ovf), tbl[i].ovf);
    end

    // asynchronous reset while an event is offered and overflow is set
    in = 4'b0100;
    evt_ready = 1'b0;
    run(20);
    check("pre-rst valid", int'(evt_valid), 1);
    check("pre-rst id", int'(evt_id), 2);
    #3 RST = 1'b1;
    #1;
    check("async rst level", int'(level), 0);
    check("async rst valid", int'(evt_valid), 0);
    check("async rst id", int'(evt_id), 0);
    check("async rst ovf", int'(evt_ovf), 0);
    @(posedge CLK);
    #1 RST = 1'b0;

    // bounce shorter than the stability window
    do_reset(1'b1);
    evt_ready = 1'b1;
    q.delete();
    for (int k = 0; k < 8; k++) begin
      in[1] = ~in[1];
      run(10);
    end
    in = 4'b0000;
    run(30);
    check("glitch level", int'(level), 0);
    check("glitch events", q.size(), 0);
    check("glitch ovf", int'(evt_ovf), 0);

    // long hold: PRESS, REPEAT at +64 then every 32, RELEASE at +1000
    do_reset(1'b1);
    evt_ready = 1'b1;
    q.delete();
    in = 4'b0100;
    run(1000);
    in = 4'b0000;
    run(30);
    check("hold count", q.size(), 32);
    if (q.size() == 32) begin
      check("hold press type", q[0].typ, 0);
      check("hold press id", q[0].id, 2);
      check("hold first repeat", q[1].cyc - q[0].cyc, 64);
      bad = 0;
      for (int k = 1; k <= 30; k++) begin
        if (q[k].typ != 2 || q[k].id != 2) bad++;
        if (k > 1 && q[k].cyc - q[k-1].cyc != 32) bad++;
      end
      check("hold repeat spacing", bad, 0);
      check("hold release type", q[31].typ, 1);
      check("hold release time", q[31].cyc - q[0].cyc, 1000);
    end

    // repeats into an occupied slot are dropped without overflow
    do_reset(1'b1);
    in = 4'b1000;
    run(200);
    check("rptdrop valid", int'(evt_valid), 1);
    check("rptdrop id", int'(evt_id), 3);
    check("rptdrop ovf", int'(evt_ovf), 0);
    q.delete();
    evt_ready = 1'b1;
    run(2);
    check("rptdrop drained", q.size(), 2);
    if (q.size() == 2) begin
      check("rptdrop first", q[0].typ * 4 + q[0].id, 0 * 4 + 3);
      check("rptdrop second", q[1].typ * 4 + q[1].id, 2 * 4 + 3);
    end
    in = 4'b0000;
    run(30);

    // simultaneous presses drain back-to-back in round-robin order
    do_reset(1'b1);
    in = 4'b1111;
    run(40);
    check("simul valid", int'(evt_valid), 1);
    check("simul id", int'(evt_id), 0);
    q.delete();
    evt_ready = 1'b1;
    run(6);
    check("simul count", q.size(), 4);
    if (q.size() == 4) begin
      bad = 0;
      for (int k = 0; k < 4; k++)
        if (q[k].id != k || q[k].typ != 0 || q[k].cyc != q[0].cyc + k) bad++;
      check("simul order", bad, 0);
    end
    in = 4'b0000;
    run(30);
    check("simul release count", q.size(), 8);
    if (q.size() == 8) begin
      bad = 0;
      for (int k = 0; k < 4; k++)
        if (q[4+k].id != k || q[4+k].typ != 1) bad++;
      check("simul release order", bad, 0);
    end
    check("simul ovf", int'(evt_ovf), 0);

    // enable=0 freezes debouncing; PRESS follows once enabled
    do_reset(1'b0);
    evt_ready = 1'b1;
    q.delete();
    in = 4'b0001;
    run(100);
    check("frozen level", int'(level), 0);
    check("frozen events", q.size(), 0);
    c0 = cyc;
    enable = 1'b1;
    run(25);
    check("enable events", q.size(), 1);
    if (q.size() == 1) begin
      check("enable press", q[0].typ * 4 + q[0].id, 0);
      check_rng("enable latency", q[0].cyc - c0, 16, 20);
    end
    check("enable level", int'(level), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
